io_step_sequencer: RTL
======================

// Module: io_step_sequencer
// PURPOSE
//  Hard-wired control-step sequencer for the bus datapath: runs fetch (T0-T2) then executes in/out/nop/halt
//  (T3), driving the bus strobes one T-state per step. Adds what the hand-driven step benches lack:
//  memory-ready wait states, N selectable in/out channels with valid/ready handshakes, halt.
//  Sits beside bus; consumes the IR opcode, drives bus control inputs and the I/O channels.
// PARAMETERS
//  N_OUT    2    output-port channels (1..8)
//  N_IN     2    input-port channels (1..8)
//  TMO_MAX  255  wait-cycle limit, used only with IO_SEQ_TIMEOUT_EN
// PORTS
//  clock         in   1      system clock, all state changes on posedge
//  clear         in   1      synchronous reset, active-low
//  run_en        in   1      1 = leave IDLE and start fetching
//  ir            in   32     IR contents (bus IR register output)
//  mem_ready     in   1      memory read data valid in MDR path
//  out_ready     in   N_OUT  per-channel consumer ready
//  in_valid      in   N_IN   per-channel input data valid
//  PCout,MARin,IncPC,Zlowin  out 1  T0 strobes
//  Zlowout,PCin,MDRin,read   out 1  T1 strobes
//  MDRout,IRin               out 1  T2 strobes
//  Gra,Rout,Rin,Inportout    out 1  T3 register/in-port strobes
//  OutPortin     out  N_OUT  one-hot out-port load strobe = out_valid
//  in_ack        out  N_IN   one-hot input-channel acknowledge
//  step          out  4      current step: IDLE 0000, T0 0001, T1 0010, T2 0011, T3 0100, HALT 1111
//  halted        out  1      1 in HALT
//  err           out  1      sticky timeout flag (0 without IO_SEQ_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (clear==0 at posedge): state IDLE; every output 0; err 0; timeout counter 0. Overrides all.
//  - Strobes are Moore decodes of the registered state; no strobe depends combinationally on inputs
//    except OutPortin/in_ack, which are gated by the selected channel index.
//  - IDLE -> T0 when run_en=1. T0 -> T1 always (PCout,MARin,IncPC,Zlowin asserted 1 cycle).
//  - T1: Zlowout,PCin,MDRin,read asserted; PCin only on the first T1 cycle; stays in T1 while
//    mem_ready=0 (read,MDRin held); -> T2 on mem_ready=1.
//  - T2: MDRout,IRin for 1 cycle -> T3.
//  - T3 decode on ir[31:27]; ch = ir[22:20] (c2 field, low bits), out-of-range ch -> treated as NOP:
//    OP_OUT: Gra,Rout,OutPortin[ch] held until out_ready[ch]=1, then -> T0 (transfer cycle inclusive).
//    OP_IN : Inportout,Gra,Rin held while in_valid[ch]=0; cycle with in_valid[ch]=1 asserts in_ack[ch]
//            and commits Rin, -> T0.
//    OP_NOP or any other opcode: 1 cycle, no strobes, -> T0.   OP_HALT: -> HALT.
//  - HALT: all strobes 0, halted=1; only reset exits. run_en ignored outside IDLE.
//  - Best-case instruction = 4 cycles; each wait cycle adds 1.
//  - Simultaneous mem_ready and clear=0: reset wins. run_en deasserted mid-instruction: completes, then T0.
// CONFIGURATION
//  IO_SEQ_TIMEOUT_EN defined: 8-bit counter clears on every state change, counts wait cycles in T1/T3;
//   on reaching TMO_MAX the wait is abandoned, err set (sticky), state -> HALT.
//  Not defined: waits are unbounded; err tied 0; no counter logic.
// STRUCTURE
//  Package io_seq_pkg: state enum/step codes, OP_IN 5'b10110, OP_OUT 5'b10111, OP_NOP 5'b11010,
//  OP_HALT 5'b11011, IR field bit positions.
//  Sub-module io_seq_wait_timer: timeout counter (instantiated only under IO_SEQ_TIMEOUT_EN).
// TESTING
//  1 out r3,ch1 (ir=0xB9900001), mem_ready=1, out_ready=2'b10 -> step 1,2,3,4, OutPortin=2'b10 in cycle 4, back to T0.
//  2 T1 with mem_ready low 3 cycles -> read/MDRin high 4 cycles, PCin high only first, IRin 1 cycle after ready.
//  3 in r2,ch0 (ir=0xB1000000), in_valid low 5 cycles -> Inportout held 6 cycles, in_ack=2'b01 exactly once.
//  4 halt (ir=0xD8000000) -> step=1111, halted=1, run_en toggling ignored; clear=0 -> IDLE, outputs 0.
//  5 clear=0 asserted mid-T3 out-wait -> next cycle all strobes 0, step=0000, no OutPortin pulse.
//  6 IO_SEQ_TIMEOUT_EN, TMO_MAX=4, out_ready=0 -> after 4 wait cycles err=1, step=1111; without macro waits forever.

Source files
------------

// File: rtl/io_seq_pkg.sv
// Shared constants for the I/O step sequencer: step codes, opcodes, IR field positions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package io_seq_pkg;

  // Step codes double as the registered state encoding, so the step port is the state itself.
  localparam logic [3:0] S_IDLE = 4'b0000;
  localparam logic [3:0] S_T0   = 4'b0001;
  localparam logic [3:0] S_T1   = 4'b0010;
  localparam logic [3:0] S_T2   = 4'b0011;
  localparam logic [3:0] S_T3   = 4'b0100;
  localparam logic [3:0] S_HALT = 4'b1111;

  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Opcode field and channel select (low bits of the c2 field).
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int CH_MSB = 22;
  localparam int CH_LSB = 20;

endpackage

// File: rtl/io_seq_wait_timer.sv
// Wait-state timeout counter: counts consecutive wait cycles, flags the cycle that reaches TMO_MAX.
// Latency: expired is combinational on wait_cyc and the registered count.
// Backpressure: none; clears whenever the sequencer is not waiting (i.e. on every state change).
// Ports: clock, clear (sync active-low), wait_cyc (sequencer is stalled this cycle), expired.
module io_seq_wait_timer #(
  parameter int TMO_MAX = 255
) (
  input  logic clock,
  input  logic clear,
  input  logic wait_cyc,
  output logic expired
);

  logic [7:0] cnt;

  // cnt holds the number of wait cycles already spent, so the TMO_MAX-th wait cycle expires.
  assign expired = wait_cyc && (cnt == 8'(TMO_MAX - 1));

  always_ff @(posedge clock) begin
    if (!clear) begin
      cnt <= 8'd0;
    end else if (wait_cyc && !expired) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= 8'd0;
    end
  end

endmodule

// File: rtl/io_step_sequencer.sv
// Hard-wired fetch/execute step sequencer: T0-T2 fetch, T3 executes in/out/nop/halt, with wait states.
// Latency: 4 cycles per instruction best case, +1 per memory or I/O wait cycle.
// Backpressure: stalls in T1 until mem_ready, in T3 until out_ready[ch] / in_valid[ch].
// Ports: clock, clear (sync active-low), run_en, ir, mem_ready, out_ready, in_valid in;
//   T0-T3 bus strobes, OutPortin (one-hot out load), in_ack (one-hot), step, halted, err out.
// Optional macro IO_SEQ_TIMEOUT_EN: bounded waits, abandon to HALT with sticky err.
module io_step_sequencer #(
  parameter int N_OUT   = 2,
  parameter int N_IN    = 2,
  parameter int TMO_MAX = 255
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run_en,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  input  logic [N_OUT-1:0] out_ready,
  input  logic [N_IN-1:0]  in_valid,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zlowin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             MDRin,
  output logic             read,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Rout,
  output logic             Rin,
  output logic             Inportout,
  output logic [N_OUT-1:0] OutPortin,
  output logic [N_IN-1:0]  in_ack,
  output logic [3:0]       step,
  output logic             halted,
  output logic             err
);

  import io_seq_pkg::*;

  logic [3:0] state;
  logic [3:0] nxt;
  logic       t1_wait;   // already spent one cycle in T1: PC load must not repeat
  logic [4:0] opcode;
  logic [2:0] ch;
  logic [7:0] out_rdy_x;
  logic [7:0] in_vld_x;
  logic [7:0] ch_hot;
  logic       out_ch_ok;
  logic       in_ch_ok;
  logic       is_out;
  logic       is_in;
  logic       tmo_expired;

  assign opcode = ir[OP_MSB:OP_LSB];
  assign ch     = ir[CH_MSB:CH_LSB];

  // Widen the channel vectors to 8 so a 3-bit index is always in range.
  assign out_rdy_x = 8'(out_ready);
  assign in_vld_x  = 8'(in_valid);
  assign ch_hot    = 8'b1 << ch;

  // A channel index beyond the instantiated count degrades the instruction to a NOP.
  assign out_ch_ok = ({29'd0, ch} < N_OUT);
  assign in_ch_ok  = ({29'd0, ch} < N_IN);

  assign is_out = (state == S_T3) && (opcode == OP_OUT) && out_ch_ok;
  assign is_in  = (state == S_T3) && (opcode == OP_IN) && in_ch_ok;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (run_en) nxt = S_T0;
      S_T0:   nxt = S_T1;
      S_T1:   if (mem_ready) nxt = S_T2;
      S_T2:   nxt = S_T3;
      S_T3: begin
        if (is_out) begin
          if (out_rdy_x[ch]) nxt = S_T0;
        end else if (is_in) begin
          if (in_vld_x[ch]) nxt = S_T0;
        end else if (opcode == OP_HALT) begin
          nxt = S_HALT;
        end else begin
          nxt = S_T0;
        end
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
    if (tmo_expired) nxt = S_HALT;
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state   <= S_IDLE;
      t1_wait <= 1'b0;
    end else begin
      state   <= nxt;
      t1_wait <= (state == S_T1) && (nxt == S_T1);
    end
  end

`ifdef IO_SEQ_TIMEOUT_EN
  logic waiting;
  logic err_q;

  assign waiting = ((state == S_T1) && !mem_ready) ||
                   (is_out && !out_rdy_x[ch]) ||
                   (is_in && !in_vld_x[ch]);

  io_seq_wait_timer #(
    .TMO_MAX(TMO_MAX)
  ) u_wait_timer (
    .clock   (clock),
    .clear   (clear),
    .wait_cyc(waiting),
    .expired (tmo_expired)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      err_q <= 1'b0;
    end else if (tmo_expired) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  localparam int unused_tmo_max = TMO_MAX;

  assign tmo_expired = 1'b0;
  assign err         = 1'b0;
`endif

  // Moore strobes from the registered step.
  assign PCout  = (state == S_T0);
  assign MARin  = (state == S_T0);
  assign IncPC  = (state == S_T0);
  assign Zlowin = (state == S_T0);

  assign Zlowout = (state == S_T1);
  assign PCin    = (state == S_T1) && !t1_wait;
  assign MDRin   = (state == S_T1);
  assign read    = (state == S_T1);

  assign MDRout = (state == S_T2);
  assign IRin   = (state == S_T2);

  assign Gra       = is_out || is_in;
  assign Rout      = is_out;
  assign Rin       = is_in;
  assign Inportout = is_in;

  // OutPortin doubles as out_valid for the whole wait; in_ack fires only on the accepting cycle.
  assign OutPortin = is_out ? ch_hot[N_OUT-1:0] : '0;
  assign in_ack    = (is_in && in_vld_x[ch]) ? ch_hot[N_IN-1:0] : '0;

  assign step   = state;
  assign halted = (state == S_HALT);

  logic unused_bits;
  assign unused_bits = &{1'b0, ir[26:23], ir[19:0], ch_hot};

endmodule
